// File: rtl/gpmc_sync_if.sv
// ============================================================================
//  Module   : gpmc_sync_if
//  Purpose  : Synchronous bridge from the AM335x GPMC muxed A/D bus into clk.
//  Options  : GPMC_SYNC_WORD_ADDR_EN - address taken from ad_s[ADDR_WIDTH:1]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpmc_sync_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] gpmc_ad,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_csn1,
    input  logic                  gpmc_wein,
    input  logic                  gpmc_oen,
    input  logic                  gpmc_clk,
    output logic                  oe,
    output logic                  we,
    output logic                  cs,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in
);

    // Control bundle order: {advn, csn1, wein, oen, gpmc_clk}; all idle high.
    localparam logic [4:0] c_CTL_IDLE = 5'b11111;

    logic [4:0]            ctl_meta_q;
    logic [4:0]            ctl_s_q;
    logic [DATA_WIDTH-1:0] ad_meta_q;
    logic [DATA_WIDTH-1:0] ad_s_q;
    logic                  gclk_q;

    logic                  advn_s;
    logic                  csn1_s;
    logic                  wein_s;
    logic                  oen_s;
    logic                  gclk_s;
    logic                  gclk_rise;
    logic                  drive_en;

    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  cs_q;
    logic                  we_q;
    logic                  oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_meta_q <= c_CTL_IDLE;
            ctl_s_q    <= c_CTL_IDLE;
            ad_meta_q  <= '0;
            ad_s_q     <= '0;
            gclk_q     <= 1'b1;
        end else begin
            ctl_meta_q <= {gpmc_advn, gpmc_csn1, gpmc_wein, gpmc_oen, gpmc_clk};
            ctl_s_q    <= ctl_meta_q;
            ad_meta_q  <= gpmc_ad;
            ad_s_q     <= ad_meta_q;
            gclk_q     <= ctl_s_q[0];
        end
    end

    assign advn_s    = ctl_s_q[4];
    assign csn1_s    = ctl_s_q[3];
    assign wein_s    = ctl_s_q[2];
    assign oen_s     = ctl_s_q[1];
    assign gclk_s    = ctl_s_q[0];
    assign gclk_rise = gclk_s & ~gclk_q;

`ifdef GPMC_SYNC_WORD_ADDR_EN
    assign addr_sel = ad_s_q[ADDR_WIDTH:1];
`else
    assign addr_sel = ad_s_q[ADDR_WIDTH-1:0];
`endif

    // Address phase takes priority over data phase on the same edge.
    always_comb begin
        address_d = address_q;
        data_d    = data_q;
        if (gclk_rise && !csn1_s) begin
            if (!advn_s) begin
                address_d = addr_sel;
            end else if (!wein_s) begin
                data_d = ad_s_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            address_q <= '0;
            data_q    <= '0;
            cs_q      <= 1'b1;
            we_q      <= 1'b1;
            oe_q      <= 1'b1;
        end else begin
            address_q <= address_d;
            data_q    <= data_d;
            cs_q      <= csn1_s;
            we_q      <= wein_s;
            oe_q      <= oen_s;
        end
    end

    assign address  = address_q;
    assign data_out = data_q;
    assign cs       = cs_q;
    assign we       = we_q;
    assign oe       = oe_q;

    // Drive enable comes straight off the synchronizer to shorten read turnaround.
    assign drive_en = ~csn1_s & ~oen_s & wein_s & ~rst;
    assign gpmc_ad  = drive_en ? data_in : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_gpmc_sync_if.sv
// ============================================================================
//  Module   : tb_gpmc_sync_if
//  Purpose  : Directed self-checking bench for gpmc_sync_if.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpmc_sync_if;

    localparam int c_DW = 16;
    localparam int c_AW = 4;
    localparam logic [c_DW-1:0] c_BUS_Z = 16'hFFFF;  // value seen through the pull-ups

    logic            clk;
    logic            rst;
    tri1  [c_DW-1:0] gpmc_ad;
    logic            gpmc_advn;
    logic            gpmc_csn1;
    logic            gpmc_wein;
    logic            gpmc_oen;
    logic            gpmc_clk;
    logic            oe;
    logic            we;
    logic            cs;
    logic [c_AW-1:0] address;
    logic [c_DW-1:0] data_out;
    logic [c_DW-1:0] data_in;

    logic            tb_drv;
    logic [c_DW-1:0] tb_ad;

    int n_chk;
    int n_pass;

    assign gpmc_ad = tb_drv ? tb_ad : {c_DW{1'bz}};

    gpmc_sync_if #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .gpmc_ad   (gpmc_ad),
        .gpmc_advn (gpmc_advn),
        .gpmc_csn1 (gpmc_csn1),
        .gpmc_wein (gpmc_wein),
        .gpmc_oen  (gpmc_oen),
        .gpmc_clk  (gpmc_clk),
        .oe        (oe),
        .we        (we),
        .cs        (cs),
        .address   (address),
        .data_out  (data_out),
        .data_in   (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [c_DW-1:0] a);
`ifdef GPMC_SYNC_WORD_ADDR_EN
        return 32'(a[c_AW:1]);
`else
        return 32'(a[c_AW-1:0]);
`endif
    endfunction

    task automatic gclk_pulse();
        gpmc_clk = 1'b1;
        tick(4);
        gpmc_clk = 1'b0;
        tick(4);
    endtask

    task automatic pins_idle();
        gpmc_advn = 1'b1;
        gpmc_csn1 = 1'b1;
        gpmc_wein = 1'b1;
        gpmc_oen  = 1'b1;
        gpmc_clk  = 1'b0;
        tb_drv    = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        tb_ad   = 16'h0000;
        data_in = 16'h1234;
        pins_idle();

        // Reset with an otherwise-active read on the pins
        rst       = 1'b1;
        gpmc_csn1 = 1'b0;
        gpmc_wein = 1'b0;
        gpmc_oen  = 1'b0;
        gpmc_advn = 1'b0;
        tick(5);
        chk("rst_cs",   32'(cs),       32'h1);
        chk("rst_we",   32'(we),       32'h1);
        chk("rst_oe",   32'(oe),       32'h1);
        chk("rst_addr", 32'(address),  32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_busz", 32'(gpmc_ad),  32'(c_BUS_Z));
        pins_idle();
        rst = 1'b0;
        tick(4);

        // Write: address 0x0004, then data 0xBEEF
        gpmc_csn1 = 1'b0;
        gpmc_advn = 1'b0;
        gpmc_wein = 1'b0;
        tb_drv    = 1'b1;
        tb_ad     = 16'h0004;
        tick(3);
        gclk_pulse();
        chk("wr_addr", 32'(address), exp_addr(16'h0004));
        gpmc_advn = 1'b1;
        tb_ad     = 16'hBEEF;
        tick(3);
        gclk_pulse();
        chk("wr_data",  32'(data_out), 32'hBEEF);
        chk("wr_addr2", 32'(address),  exp_addr(16'h0004));
        chk("wr_cs",    32'(cs),       32'h0);
        chk("wr_we",    32'(we),       32'h0);
        chk("wr_oe",    32'(oe),       32'h1);

        // Further data beat overwrites data at the same address
        tb_ad = 16'h1111;
        tick(3);
        gclk_pulse();
        chk("wr2_data", 32'(data_out), 32'h1111);
        chk("wr2_addr", 32'(address),  exp_addr(16'h0004));

        // Deselect: values hold, controls return high
        pins_idle();
        tick(4);
        chk("hold_cs",   32'(cs),       32'h1);
        chk("hold_we",   32'(we),       32'h1);
        chk("hold_addr", 32'(address),  exp_addr(16'h0004));
        chk("hold_data", 32'(data_out), 32'h1111);

        // Read: oe latency is exactly 3 clk, bus driven within 3 clk
        data_in   = 16'h1234;
        gpmc_csn1 = 1'b0;
        gpmc_oen  = 1'b0;
        tick(2);
        chk("rd_oe_lat", 32'(oe), 32'h1);
        tick(1);
        chk("rd_oe",  32'(oe),      32'h0);
        chk("rd_bus", 32'(gpmc_ad), 32'h1234);
        data_in = 16'hA55A;
        tick(1);
        chk("rd_bus2", 32'(gpmc_ad), 32'hA55A);
        gpmc_oen = 1'b1;
        tick(3);
        chk("rd_busz", 32'(gpmc_ad), 32'(c_BUS_Z));
        chk("rd_oe_off", 32'(oe), 32'h1);

        // Chip-select gating: nothing latches, bus not driven
        pins_idle();
        tb_drv    = 1'b1;
        tb_ad     = 16'h00FF;
        gpmc_advn = 1'b0;
        gpmc_wein = 1'b0;
        tick(3);
        gclk_pulse();
        gpmc_advn = 1'b1;
        tick(3);
        gclk_pulse();
        chk("cs_addr", 32'(address),  exp_addr(16'h0004));
        chk("cs_data", 32'(data_out), 32'h1111);
        tb_drv    = 1'b0;
        gpmc_wein = 1'b1;
        gpmc_oen  = 1'b0;
        tick(4);
        chk("cs_busz", 32'(gpmc_ad), 32'(c_BUS_Z));

        // Phase priority: ADV low with WE low updates only the address
        pins_idle();
        gpmc_csn1 = 1'b0;
        gpmc_advn = 1'b0;
        gpmc_wein = 1'b0;
        tb_drv    = 1'b1;
        tb_ad     = 16'h0006;
        tick(3);
        gclk_pulse();
        chk("pri_addr", 32'(address),  exp_addr(16'h0006));
        chk("pri_data", 32'(data_out), 32'h1111);

        // Reset in the middle of a data phase
        gpmc_advn = 1'b1;
        tb_ad     = 16'hCAFE;
        tick(3);
        rst      = 1'b1;
        tick(2);
        gpmc_clk = 1'b1;
        tick(3);
        chk("mrst_addr", 32'(address),  32'h0);
        chk("mrst_data", 32'(data_out), 32'h0);
        chk("mrst_cs",   32'(cs),       32'h1);
        chk("mrst_we",   32'(we),       32'h1);
        rst = 1'b0;
        tick(4);
        chk("mrst_noedge", 32'(data_out), 32'h0);
        chk("mrst_cs_live", 32'(cs), 32'h0);
        gpmc_clk  = 1'b0;
        gpmc_advn = 1'b0;
        tb_ad     = 16'h000A;
        tick(3);
        gclk_pulse();
        gpmc_advn = 1'b1;
        tb_ad     = 16'h5A5A;
        tick(3);
        gclk_pulse();
        chk("post_addr", 32'(address),  exp_addr(16'h000A));
        chk("post_data", 32'(data_out), 32'h5A5A);
        chk("post_we",   32'(we),       32'h0);

        pins_idle();
        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
